// File: rtl/floo_test_pkg.sv
// Shared types and constants for the NoC test endpoints.
//
// Contents:
//   slave_type_e        latency mode of a test slave (fast, slow, pseudo-random mix)
//   LfsrTaps            tap mask of the 16-bit Fibonacci LFSR (bits 15/13/12/10)
//   FastLatencyDefault  default latency of a fast request, in cycles
//   SlowLatencyDefault  default latency of a slow request, in cycles
//   lfsr_feedback()     shift-in bit of the LFSR for a given state
package floo_test_pkg;

    typedef enum logic [1:0] {
        FastSlave,
        SlowSlave,
        MixedSlave
    } slave_type_e;

    // Taps 16/14/13/11 in 1-based polynomial notation, i.e. state bits 15/13/12/10.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    localparam int unsigned FastLatencyDefault = 1;
    localparam int unsigned SlowLatencyDefault = 8;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LfsrTaps);
    endfunction

endpackage

// File: rtl/floo_test_lfsr16.sv
// 16-bit Fibonacci LFSR used as a cheap pseudo-random source in test endpoints.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset, loads Seed
//   en_i     advance the register by one step on the next rising edge
//   lfsr_o   current state (valid before the shift that en_i requests)
//
// Seed must be non-zero, otherwise the register locks up at zero.
module floo_test_lfsr16
    import floo_test_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    if (Seed == 16'h0000) begin : gen_bad_seed
        $error("floo_test_lfsr16: Seed must be non-zero");
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/floo_test_latency_slave.sv
// Request/response endpoint model for NoC testbenches.
//
// Terminates requests from a chimney's target-side manager port and answers each one, in
// order, after a per-request latency (fast, slow, or chosen per request by an LFSR). Read
// responses return the zero-extended request address as data; write responses return zero.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset; drops every held request
//   req_valid_i  request valid
//   req_ready_o  request ready, depends on registered fill level only
//   req_id_i     request ID
//   req_addr_i   request address
//   req_write_i  1 = write, 0 = read
//   rsp_valid_o  response valid (head entry has finished its countdown)
//   rsp_ready_i  response ready
//   rsp_id_o     echoed ID of the head entry
//   rsp_write_o  echoed write flag of the head entry
//   rsp_rdata_o  zero-extended head address for reads, zero for writes
//   busy_o       at least one request held
//
// Storage is a circular buffer with a down-counter per entry. Every held entry counts
// down on every edge regardless of its position, so a request queued behind a stalled head
// has usually finished its countdown by the time it reaches the head.
module floo_test_latency_slave
    import floo_test_pkg::*;
#(
    parameter slave_type_e  SlaveType      = FastSlave,
    parameter int unsigned  NumOutstanding = 4,
    parameter int unsigned  IdWidth        = 3,
    parameter int unsigned  AddrWidth      = 32,
    parameter int unsigned  DataWidth      = 64,
    parameter int unsigned  FastLatency    = FastLatencyDefault,
    parameter int unsigned  SlowLatency    = SlowLatencyDefault,
    parameter logic [15:0]  LfsrSeed       = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 rsp_write_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 busy_o
);

    localparam int unsigned CntWidth   = $clog2(SlowLatency + 1);
    localparam int unsigned PtrWidth   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CountWidth = $clog2(NumOutstanding + 1);

    localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(NumOutstanding - 1);
    localparam logic [CountWidth-1:0] MaxCount = CountWidth'(NumOutstanding);
    localparam logic [CntWidth-1:0]   FastCnt  = CntWidth'(FastLatency);
    localparam logic [CntWidth-1:0]   SlowCnt  = CntWidth'(SlowLatency);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (FastLatency == 0) begin : gen_bad_fast_latency
        $error("floo_test_latency_slave: FastLatency must be at least 1");
    end
    if (SlowLatency < FastLatency) begin : gen_bad_slow_latency
        $error("floo_test_latency_slave: SlowLatency must be >= FastLatency");
    end
    if (DataWidth < AddrWidth) begin : gen_bad_data_width
        $error("floo_test_latency_slave: DataWidth must be >= AddrWidth");
    end
    if (LfsrSeed == 16'h0000) begin : gen_bad_seed
        $error("floo_test_latency_slave: LfsrSeed must be non-zero");
    end
    if (NumOutstanding == 0) begin : gen_bad_depth
        $error("floo_test_latency_slave: NumOutstanding must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic                 write;
        logic [AddrWidth-1:0] addr;
        logic [CntWidth-1:0]  cnt;
    } entry_t;

    entry_t                    entry_q [NumOutstanding];
    entry_t                    entry_d [NumOutstanding];
    logic [NumOutstanding-1:0] valid_q, valid_d;
    logic [PtrWidth-1:0]       wptr_q, wptr_d;
    logic [PtrWidth-1:0]       rptr_q, rptr_d;
    logic [CountWidth-1:0]     count_q, count_d;

    entry_t                    head;
    logic                      push, pop;
    logic [CntWidth-1:0]       latency;
    logic [15:0]               lfsr;

    // Only bit 0 of the LFSR selects the latency; the rest is carried for the sequence.
    logic                      unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[15:1];

    // ------------------------------------------------------------------------
    // Latency source
    // ------------------------------------------------------------------------
    // The LFSR steps on every accepted request in every mode, so switching a bench from
    // fast/slow to mixed does not change where the random sequence starts.
    floo_test_lfsr16 #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (push),
        .lfsr_o (lfsr)
    );

    // Uses the LFSR value before this edge's shift.
    always_comb begin
        latency = FastCnt;
        if (SlaveType == SlowSlave) begin
            latency = SlowCnt;
        end else if (SlaveType == MixedSlave && lfsr[0]) begin
            latency = SlowCnt;
        end
    end

    // ------------------------------------------------------------------------
    // Handshakes and outputs
    // ------------------------------------------------------------------------
    assign head        = entry_q[rptr_q];
    // Fill level only: a pop on the same edge never frees a slot for a push.
    assign req_ready_o = (count_q < MaxCount);
    assign rsp_valid_o = (count_q != '0) && (head.cnt == '0);
    assign busy_o      = (count_q != '0);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_comb begin
        rsp_id_o    = '0;
        rsp_write_o = 1'b0;
        rsp_rdata_o = '0;
        if (count_q != '0) begin
            rsp_id_o    = head.id;
            rsp_write_o = head.write;
            if (!head.write) begin
                rsp_rdata_o[AddrWidth-1:0] = head.addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        // Countdown of every held entry, saturating at zero.
        for (int unsigned i = 0; i < NumOutstanding; i++) begin
            if (valid_q[i] && entry_q[i].cnt != '0) begin
                entry_d[i].cnt = entry_q[i].cnt - 1'b1;
            end
        end

        if (pop) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        end

        // The push slot is never a held entry, so the load below is not decremented.
        if (push) begin
            entry_d[wptr_q].id    = req_id_i;
            entry_d[wptr_q].write = req_write_i;
            entry_d[wptr_q].addr  = req_addr_i;
            entry_d[wptr_q].cnt   = latency;
            valid_d[wptr_q]       = 1'b1;
            wptr_d                = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumOutstanding; i++) begin
                entry_q[i] <= '0;
            end
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumOutstanding; i++) begin
                entry_q[i] <= entry_d[i];
            end
            valid_q <= valid_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_floo_test_latency_slave.sv
// Scoreboard bench for floo_test_latency_slave. One instance per latency mode shares the
// request/response inputs; sel picks which instance is observed and driven meaningfully.
module tb_floo_test_latency_slave;
    import floo_test_pkg::*;

    localparam int NumOut  = 4;
    localparam int FastLat = 1;
    localparam int SlowLat = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_id;
    logic [31:0] req_addr;
    logic        req_write;
    logic        rsp_ready;
    logic [1:0]  sel;

    logic [2:0]       req_ready_a, rsp_valid_a, rsp_write_a, busy_a;
    logic [2:0][2:0]  rsp_id_a;
    logic [2:0][63:0] rsp_rdata_a;

    logic        req_ready_m, rsp_valid_m, rsp_write_m, busy_m;
    logic [2:0]  rsp_id_m;
    logic [63:0] rsp_rdata_m;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    floo_test_latency_slave #(
        .SlaveType (FastSlave), .NumOutstanding (NumOut), .IdWidth (3), .AddrWidth (32),
        .DataWidth (64), .FastLatency (FastLat), .SlowLatency (SlowLat), .LfsrSeed (16'hACE1)
    ) u_fast (
        .clk_i (clk), .rst_ni (rst_n), .req_valid_i (req_valid), .req_ready_o (req_ready_a[0]),
        .req_id_i (req_id), .req_addr_i (req_addr), .req_write_i (req_write),
        .rsp_valid_o (rsp_valid_a[0]), .rsp_ready_i (rsp_ready), .rsp_id_o (rsp_id_a[0]),
        .rsp_write_o (rsp_write_a[0]), .rsp_rdata_o (rsp_rdata_a[0]), .busy_o (busy_a[0])
    );

    floo_test_latency_slave #(
        .SlaveType (SlowSlave), .NumOutstanding (NumOut), .IdWidth (3), .AddrWidth (32),
        .DataWidth (64), .FastLatency (FastLat), .SlowLatency (SlowLat), .LfsrSeed (16'hACE1)
    ) u_slow (
        .clk_i (clk), .rst_ni (rst_n), .req_valid_i (req_valid), .req_ready_o (req_ready_a[1]),
        .req_id_i (req_id), .req_addr_i (req_addr), .req_write_i (req_write),
        .rsp_valid_o (rsp_valid_a[1]), .rsp_ready_i (rsp_ready), .rsp_id_o (rsp_id_a[1]),
        .rsp_write_o (rsp_write_a[1]), .rsp_rdata_o (rsp_rdata_a[1]), .busy_o (busy_a[1])
    );

    floo_test_latency_slave #(
        .SlaveType (MixedSlave), .NumOutstanding (NumOut), .IdWidth (3), .AddrWidth (32),
        .DataWidth (64), .FastLatency (FastLat), .SlowLatency (SlowLat), .LfsrSeed (16'hACE1)
    ) u_mixed (
        .clk_i (clk), .rst_ni (rst_n), .req_valid_i (req_valid), .req_ready_o (req_ready_a[2]),
        .req_id_i (req_id), .req_addr_i (req_addr), .req_write_i (req_write),
        .rsp_valid_o (rsp_valid_a[2]), .rsp_ready_i (rsp_ready), .rsp_id_o (rsp_id_a[2]),
        .rsp_write_o (rsp_write_a[2]), .rsp_rdata_o (rsp_rdata_a[2]), .busy_o (busy_a[2])
    );

    always_comb begin
        req_ready_m = req_ready_a[sel];
        rsp_valid_m = rsp_valid_a[sel];
        rsp_write_m = rsp_write_a[sel];
        busy_m      = busy_a[sel];
        rsp_id_m    = rsp_id_a[sel];
        rsp_rdata_m = rsp_rdata_a[sel];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard: pushed on request acceptance, popped/compared on response
    // ------------------------------------------------------------------------
    typedef struct {
        logic [2:0]  id;
        logic        wr;
        logic [63:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] lfsr_m = 16'hACE1;
    logic        stalled = 1'b0;
    logic        head_seen = 1'b0;
    int          last_pop = 0;
    int          acc_edge_id [8];
    int          pop_edge_id [8];

    always @(negedge clk) begin
        exp_t e;
        int   first;
        if (!rst_n) begin
            sb.delete();
            lfsr_m    = 16'hACE1;
            stalled   = 1'b0;
            head_seen = 1'b0;
            last_pop  = 0;
        end else begin
            check("busy", busy_m, sb.size() != 0);
            check("req_ready", req_ready_m, sb.size() < NumOut);
            if (stalled) check("valid_held", rsp_valid_m, 1);
            if (rsp_valid_m) begin
                check("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    if (!head_seen) begin
                        first = e.acc + e.lat;
                        if (last_pop > first) first = last_pop;
                        check("first_valid_edge", edge_cnt, first);
                        head_seen = 1'b1;
                    end
                    check("rsp_id", rsp_id_m, e.id);
                    check("rsp_write", rsp_write_m, e.wr);
                    check("rsp_rdata", rsp_rdata_m, e.rdata);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        last_pop = edge_cnt + 1;
                        pop_edge_id[e.id] = edge_cnt + 1;
                        head_seen = 1'b0;
                    end
                end
            end
            stalled = rsp_valid_m && !rsp_ready;
            if (req_valid && req_ready_m) begin
                e.id    = req_id;
                e.wr    = req_write;
                e.rdata = req_write ? 64'h0 : {32'h0, req_addr};
                e.acc   = edge_cnt + 1;
                if (sel == 2'd0)      e.lat = FastLat;
                else if (sel == 2'd1) e.lat = SlowLat;
                else                  e.lat = lfsr_m[0] ? SlowLat : FastLat;
                lfsr_m = lfsr_next(lfsr_m);
                acc_edge_id[req_id] = edge_cnt + 1;
                sb.push_back(e);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drivers (all input changes happen 1 time unit after a rising edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic [2:0] id, input logic [31:0] addr, input logic wr);
        int n = 0;
        req_valid = 1'b1;
        req_id    = id;
        req_addr  = addr;
        req_write = wr;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_m && n < 200);
        if (!req_ready_m) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] mode);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sel   = mode;
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy_m) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", sb.size() == 0 && !busy_m, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_id    = '0;
        req_addr  = '0;
        req_write = 1'b0;
        rsp_ready = 1'b1;
        sel       = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_busy", busy_m, 0);
        check("reset_req_ready", req_ready_m, 1);
        check("reset_rsp_valid", rsp_valid_m, 0);
        @(posedge clk);
        #1;

        // Fast read: valid after E1, handshake at E2
        send(3'd2, 32'h0001_0040, 1'b0);
        @(negedge clk);
        check("t1_not_valid_after_e0", rsp_valid_m, 0);
        @(negedge clk);
        check("t1_valid_after_e1", rsp_valid_m, 1);
        check("t1_id", rsp_id_m, 3'd2);
        check("t1_rdata", rsp_rdata_m, 64'h0000_0000_0001_0040);
        @(posedge clk);
        #1;
        wait_idle(50);

        // Slow write, response back-pressured for 3 cycles
        do_reset(2'd1);
        rsp_ready = 1'b0;
        send(3'd5, 32'hDEAD_BEEC, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_m && n < 50);
        // First negedge after send is still in the accept cycle, so E8 is the 9th.
        check("t2_first_valid_negedge", n, 9);
        check("t2_write", rsp_write_m, 1);
        check("t2_rdata", rsp_rdata_m, 64'h0);
        repeat (3) @(negedge clk);
        check("t2_valid_stalled", rsp_valid_m, 1);
        check("t2_id_stalled", rsp_id_m, 3'd5);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle(50);

        // Full buffer: 5th request waits until one edge after the first pop
        do_reset(2'd0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'(i), 32'h0000_0100 + 32'(i * 4), 1'b0);
        fork
            send(3'd4, 32'h0000_0110, 1'b0);
            begin
                repeat (4) @(negedge clk);
                check("t3_full_not_ready", req_ready_m, 0);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_idle(50);
        check("t3_id4_one_edge_after_pop", acc_edge_id[4], pop_edge_id[0] + 1);

        // Mixed latencies, in-order return
        do_reset(2'd2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(3'(i), 32'h2000_0000 + 32'(i * 16), (i % 3) == 0);
        wait_idle(400);

        // Streaming: push and pop on the same edge, pointers wrap
        do_reset(2'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(3'(i), 32'h0000_3000 + 32'(i), (i % 2) == 1);
        wait_idle(50);

        // Asynchronous reset with requests outstanding
        do_reset(2'd0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'(i + 1), 32'h0000_4000 + 32'(i), 1'b0);
        repeat (2) @(negedge clk);
        check("t6_valid_before_reset", rsp_valid_m, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async_drop", rsp_valid_m, 0);
        check("t6_busy_async_drop", busy_m, 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_busy_after_release", busy_m, 0);
        check("t6_ready_after_release", req_ready_m, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_stale_rsp", sb.size() == 0 && !busy_m, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
